// File: rtl/cim_pkg.sv
// Shared width encodings, FSM state type and the final-bit decode used by
// both the global controller and the shift-accumulate consumer.
package cim_pkg;

    localparam logic [1:0] W8  = 2'b00;
    localparam logic [1:0] W12 = 2'b01;
    localparam logic [1:0] W16 = 2'b10;

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} bs_state_t;

    // Encoding 2'b11 is treated as 8b so a stray code still terminates a word.
    function automatic logic [3:0] last_sel(input logic [1:0] inwidth);
        case (inwidth)
            W12:     return 4'd11;
            W16:     return 4'd15;
            default: return 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/bs_term_gen.sv
// Combinational bit-weight term: sign-extend psum to full width, shift by
// the bit index, and optionally negate for the two's-complement sign bit.
module bs_term_gen #(
    parameter int PSUM_W = 10
) (
    input  logic signed [PSUM_W-1:0]  psum,
    input  logic        [3:0]         sel,
    input  logic                      neg,
    output logic signed [PSUM_W+15:0] term
);

    logic signed [PSUM_W+15:0] ext;
    logic signed [PSUM_W+15:0] shf;

    // 16 guard bits cover the largest shift, so nothing is ever truncated.
    always_comb begin
        ext  = {{16{psum[PSUM_W-1]}}, psum};
        shf  = ext <<< sel;
        term = neg ? -shf : shf;
    end

endmodule

// File: rtl/bs_shift_accum.sv
// Bit-serial shift-accumulate: weights each per-bit partial sum by 2^sel,
// emits one dot-product result per word and flags malformed sel/st streams.
module bs_shift_accum
    import cim_pkg::*;
#(
    parameter int PSUM_W    = 10,
    parameter int SIGNED_IN = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [1:0]                inwidth,
    input  logic                      st,
    input  logic [3:0]                sel,
    input  logic signed [PSUM_W-1:0]  psum,
    input  logic                      err_clr,
    output logic signed [PSUM_W+15:0] result,
    output logic                      out_valid,
    output logic [1:0]                out_width,
    output logic                      seq_err
);

    bs_state_t                 state;
    logic signed [PSUM_W+15:0] acc;
    logic signed [PSUM_W+15:0] term;
    logic [3:0]                exp_sel;
    logic [1:0]                wq;
    logic [3:0]                last;
    logic                      neg;

    // last is always >= 7, so a start cycle (sel = 0) is never negated.
    assign last = last_sel(wq);
    assign neg  = (SIGNED_IN != 0) && !st && (sel == last);

    bs_term_gen #(.PSUM_W(PSUM_W)) u_term (
        .psum (psum),
        .sel  (sel),
        .neg  (neg),
        .term (term)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            exp_sel   <= '0;
            wq        <= W8;
            result    <= '0;
            out_valid <= 1'b0;
            out_width <= W8;
            seq_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // Any violation below overrides this clear in the same cycle.
            if (err_clr)
                seq_err <= 1'b0;

            if (st) begin
                if (sel == 4'd0) begin
                    acc     <= term;
                    wq      <= inwidth;
                    exp_sel <= 4'd1;
                    state   <= ACCUM;
                    if (state == ACCUM)
                        seq_err <= 1'b1;
                end else begin
                    seq_err <= 1'b1;
                    state   <= IDLE;
                end
            end else if (state == ACCUM) begin
                if (sel != exp_sel) begin
                    seq_err <= 1'b1;
                    state   <= IDLE;
                end else if (sel == last) begin
                    result    <= acc + term;
                    out_width <= wq;
                    out_valid <= 1'b1;
                    exp_sel   <= 4'd0;
                    state     <= IDLE;
                end else begin
                    acc     <= acc + term;
                    exp_sel <= exp_sel + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bs_shift_accum.sv
// Directed bench: signed and unsigned instances share one stimulus stream;
// expected results are hand-computed per vector.
module tb_bs_shift_accum;
    import cim_pkg::*;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                st = 1'b0;
    logic                err_clr = 1'b0;
    logic [1:0]          inwidth = W8;
    logic [3:0]          sel = '0;
    logic signed [9:0]   psum = '0;
    logic signed [9:0]   ps [16];

    logic signed [25:0]  result_s, result_u;
    logic                ov_s, ov_u, err_s, err_u;
    logic [1:0]          ow_s, ow_u;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fin_cyc = 0;

    int      np_s = 0, np_u = 0;
    longint  res_s = 0, res_s_prev = 0, res_u = 0, res_u_prev = 0;
    int      pc_s = 0, pc_s_prev = 0;
    int      pw_s = 0, pw_s_prev = 0, pw_u = 0;

    bs_shift_accum #(.PSUM_W(10), .SIGNED_IN(1)) du_s (
        .clk(clk), .rstn(rstn), .inwidth(inwidth), .st(st), .sel(sel),
        .psum(psum), .err_clr(err_clr), .result(result_s),
        .out_valid(ov_s), .out_width(ow_s), .seq_err(err_s)
    );

    bs_shift_accum #(.PSUM_W(10), .SIGNED_IN(0)) du_u (
        .clk(clk), .rstn(rstn), .inwidth(inwidth), .st(st), .sel(sel),
        .psum(psum), .err_clr(err_clr), .result(result_u),
        .out_valid(ov_u), .out_width(ow_u), .seq_err(err_u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov_s) begin
            np_s++;
            res_s_prev = res_s;  res_s = result_s;
            pc_s_prev  = pc_s;   pc_s  = cyc;
            pw_s_prev  = pw_s;   pw_s  = ow_s;
        end
        if (ov_u) begin
            np_u++;
            res_u_prev = res_u;  res_u = result_u;
            pw_u = ow_u;
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            st = 1'b0; sel = '0; psum = '0; err_clr = 1'b0;
        end
    endtask

    // Drives bits 0..n-1 of one word; tog flips inwidth to 8b from bit 3 on.
    task automatic word(input logic [1:0] w, input int n, input bit tog);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st      = (i == 0);
            sel     = 4'(i);
            psum    = ps[i];
            inwidth = (tog && i >= 3) ? W8 : w;
        end
        fin_cyc = cyc;
    endtask

    task automatic fill(input logic signed [9:0] v);
        for (int i = 0; i < 16; i++) ps[i] = v;
    endtask

    initial begin
        int n0, m0;
        int seqv [5] = '{0, 1, 2, 3, 5};

        idle(2);
        chk("rst result_s", result_s, 0);
        chk("rst out_valid_s", ov_s, 0);
        chk("rst out_width_s", ow_s, 0);
        chk("rst seq_err_s", err_s, 0);
        chk("rst result_u", result_u, 0);
        @(negedge clk) rstn = 1'b1;
        idle(1);

        // psum 3 at bits 0 and 2: 3 + 12
        fill(0); ps[0] = 3; ps[2] = 3;
        n0 = np_s;
        word(W8, 8, 0); idle(3);
        chk("w8 pulses_s", np_s - n0, 1);
        chk("w8 result_s", res_s, 15);
        chk("w8 result_u", res_u, 15);
        chk("w8 latency", pc_s - fin_cyc, 1);
        chk("w8 out_width", pw_s, 0);
        chk("w8 valid one cycle", ov_s, 0);

        fill(1);
        word(W8, 8, 0); idle(3);
        chk("w8 ones result_s", res_s, -1);
        chk("w8 ones result_u", res_u, 255);

        fill(-2);
        word(W16, 16, 0); idle(3);
        chk("w16 result_s", res_s, 2);
        chk("w16 result_u", res_u, -131070);
        chk("w16 out_width", pw_s, 2);

        // back-to-back 12b words, inwidth wiggled during word 1
        fill(1);
        n0 = np_s; m0 = np_u;
        word(W12, 12, 1); word(W12, 12, 0); idle(3);
        chk("b2b pulses_s", np_s - n0, 2);
        chk("b2b pulses_u", np_u - m0, 2);
        chk("b2b spacing", pc_s - pc_s_prev, 12);
        chk("b2b res1_u", res_u_prev, 4095);
        chk("b2b res2_u", res_u, 4095);
        chk("b2b res1_s", res_s_prev, -1);
        chk("b2b res2_s", res_s, -1);
        chk("b2b width1", pw_s_prev, 1);
        chk("b2b width2", pw_s, 1);
        chk("b2b width_u", pw_u, 1);
        chk("b2b no err", err_s, 0);

        // skipped bit index
        n0 = np_s; m0 = np_u;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            st = (i == 0); sel = 4'(seqv[i]); psum = 10'sd1; inwidth = W8;
        end
        idle(12);
        chk("skip seq_err_s", err_s, 1);
        chk("skip seq_err_u", err_u, 1);
        chk("skip no pulse_s", np_s - n0, 0);
        chk("skip no pulse_u", np_u - m0, 0);
        chk("skip result held", res_u, 4095);

        @(negedge clk) err_clr = 1'b1;
        idle(1);
        chk("clr seq_err", err_s, 0);

        @(negedge clk) begin st = 1'b1; sel = 4'd4; end
        idle(1);
        chk("st sel4 seq_err", err_s, 1);

        @(negedge clk) err_clr = 1'b1;
        idle(1);
        chk("clr2 seq_err", err_s, 0);
        @(negedge clk) begin st = 1'b1; sel = 4'd4; err_clr = 1'b1; end
        idle(1);
        chk("set beats clr", err_u, 1);
        @(negedge clk) err_clr = 1'b1;
        idle(1);

        fill(0); ps[0] = 3; ps[2] = 3;
        word(W8, 8, 0); idle(3);
        chk("clean after err_s", res_s, 15);
        chk("clean after err_u", res_u, 15);
        chk("clean no err", err_s, 0);

        // reset mid-word at bit 5
        fill(1);
        n0 = np_s;
        word(W8, 6, 0);
        @(negedge clk) begin rstn = 1'b0; st = 1'b0; sel = '0; end
        idle(2);
        chk("mrst result_s", result_s, 0);
        chk("mrst result_u", result_u, 0);
        chk("mrst out_width", ow_s, 0);
        chk("mrst out_valid", ov_s, 0);
        chk("mrst no pulse", np_s - n0, 0);
        @(negedge clk) rstn = 1'b1;
        idle(1);
        word(W8, 8, 0); idle(3);
        chk("post rst pulses", np_s - n0, 1);
        chk("post rst result_s", res_s, -1);
        chk("post rst result_u", res_u, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bs_shift_accum.md
# bs_shift_accum

Bit-serial shift-accumulate unit at the consumer end of the bit-select sequencing interface (`sel`/`st`) driven by the global controller. Each cycle the macro's adder tree produces one partial sum for input bit `sel`. This block:
- weights each partial sum by 2^sel and accumulates it;
- applies two's-complement sign weighting to the final bit;
- emits one full-precision dot-product result per input word.

It also checks that the `sel`/`st` sequence is well-formed and flags violations.

## Interface
- `PSUM_W`, 10, signed partial-sum width from the adder tree.
- `SIGNED_IN`, 1, 1 = input words are two's complement (MSB weight negative); 0 = unsigned.
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `inwidth`  in  2  input precision: 00 = 8b, 01 = 12b, 10 = 16b, 11 = 8b.
- `st`  in  1  start-of-word; high exactly on the cycle `sel` = 0.
- `sel`  in  4  bit index of the current partial sum, LSB first.
- `psum`  in  PSUM_W  signed partial sum for bit `sel`.
- `err_clr`  in  1  synchronous clear of `seq_err`.
- `result`  out  PSUM_W+16  signed accumulated result; held until the next result.
- `out_valid`  out  1  one-cycle pulse: `result` updated.
- `out_width`  out  2  latched `inwidth` of the word in `result`.
- `seq_err`  out  1  sticky protocol-violation flag.

## Operation
- Internal state: `acc` (PSUM_W+16, signed), `exp_sel` (4b), `busy`, `wq` (latched width), `last` = 7/11/15 decoded from `wq`.
- Per-cycle term: term = sign-extend(`psum`) << `sel`, computed at full PSUM_W+16 width with no truncation. Max magnitude is 2^(PSUM_W-1)·2^15, so the result never overflows.
- Final-bit rule: the final bit is the one where `sel` == `last`. If `SIGNED_IN` = 1, the final-bit term is subtracted; otherwise it is added. All other terms are added.
- `st` = 1, `sel` = 0:
  - Actions: `acc` <= term; `wq` <= `inwidth`; `busy` <= 1; `exp_sel` <= 1.
  - If `busy` was already 1, set `seq_err` and discard the previous word.
- `st` = 1, `sel` != 0: set `seq_err`; `busy` <= 0.
- `st` = 0, `busy` = 1, `sel` == `exp_sel`:
  - If `sel` != `last`: `acc` <= `acc` + term; `exp_sel` <= `exp_sel` + 1.
  - If `sel` == `last`:
    - Actions: `result` <= `acc` ± term; `out_width` <= `wq`; `out_valid` <= 1; `busy` <= 0; `exp_sel` <= 0.
- `st` = 0, `busy` = 1, `sel` != `exp_sel`: set `seq_err`; `busy` <= 0; no `out_valid`; `result` unchanged.
- `st` = 0, `busy` = 0: idle; `psum` and `sel` are ignored; no error.
- `inwidth` changes mid-word: no effect, because `wq` governs the word in flight.
- `seq_err`:
  - Clears only on `err_clr` or reset.
  - If a violation and `err_clr` occur in the same cycle, the set wins.
  - `seq_err` never blocks operation.
- State machine: IDLE (`busy` = 0) and ACCUM (`busy` = 1), with transitions as listed above.

## Timing
- Reset values: `result` = 0, `out_valid` = 0, `out_width` = 00, `seq_err` = 0; internal `acc` = 0, `busy` = 0, `exp_sel` = 0.
- Latency: `out_valid` rises on the cycle after the final-bit cycle.
- `out_valid` is high for exactly one cycle.
- Throughput: one word per 8/12/16 cycles. Back-to-back words (`st` on the cycle after the final bit) are accepted with no bubble; the previous word's `out_valid` is then concurrent with the new word's first accumulation.
- Reset asserted mid-word: all state returns to reset values and no `out_valid` is produced for the partial word. After `rstn` deasserts, the first `st` starts a new word.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `cim_pkg` holds:
  - width encodings `W8` = 2'b00, `W12` = 2'b01, `W16` = 2'b10;
  - function `last_sel(inwidth)` returning 7/11/15, with 11 mapping to 7. The global controller uses the same function.
- One natural sub-module, `bs_term_gen`: combinational sign-extend, shift by `sel`, and conditional negate. It produces a PSUM_W+16 signed term.
- The FSM, checker and accumulator register sit in the top level.

## Test plan
- 8b, SIGNED_IN = 1. Drive `psum` = 3 at `sel` 0 and 2, 0 at all other bits. Require `result` = 15, `out_valid` one cycle after `sel` = 7, `out_width` = 00.
- 8b signed, `psum` = 1 on all 8 bits. Require `result` = 127 − 128 = −1.
- 16b signed, `psum` = −2 on all 16 bits. Require `result` = −65534 + 65536 = 2. Repeat with SIGNED_IN = 0 and require −131070.
- 12b, two back-to-back words, each with `psum` = 1 on all bits (SIGNED_IN = 0). Toggle `inwidth` to 00 during word 1.
  - Require two `out_valid` pulses 12 cycles apart, each with `result` = 4095 and `out_width` = 01.
- Protocol errors:
  - `sel` sequence 0,1,2,3,5: `seq_err` = 1 and no `out_valid`.
  - `st` with `sel` = 4: `seq_err` = 1.
  - `err_clr` pulse: `seq_err` = 0.
  - The next clean word produces a correct result.
- `rstn` low at `sel` = 5 of an 8b word: all outputs return to 0 and no `out_valid`. The following word produces the correct result.
